// File: rtl/heartbeat_sequencer.sv
// Heartbeat LED sequencer: issues one beat every P ticks (P chosen by the rate class
// latched at beat start), holding led high for the first SYSTOLE_TICKS ticks of each beat.
module heartbeat_sequencer #(
   parameter int PERIOD0      = 48,
   parameter int PERIOD1      = 32,
   parameter int PERIOD2      = 20,
   parameter int PERIOD3      = 12,
   parameter int SYSTOLE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       tick,
   input  logic [1:0] heartbeat,
   output logic       beat,
   output logic       led,
   output logic [1:0] rate_active,
   output logic [7:0] beat_count,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SYSTOLE  = 2'd1,
      DIASTOLE = 2'd2
   } state_t;

   // Terminal counts are stored as P-1 so a 256-tick period still fits in 8 bits.
   localparam logic [7:0] PM1_0 = 8'(PERIOD0 - 1);
   localparam logic [7:0] PM1_1 = 8'(PERIOD1 - 1);
   localparam logic [7:0] PM1_2 = 8'(PERIOD2 - 1);
   localparam logic [7:0] PM1_3 = 8'(PERIOD3 - 1);
   localparam logic [8:0] SYS_TICKS = 9'(SYSTOLE_TICKS);

   state_t     state;
   logic [7:0] cnt;
   logic [7:0] period_m1;
   logic [7:0] cnt_inc;
   logic       stay_systole;

   always_comb begin
      period_m1 = PM1_0;
      case (rate_active)
         2'd0:    period_m1 = PM1_0;
         2'd1:    period_m1 = PM1_1;
         2'd2:    period_m1 = PM1_2;
         default: period_m1 = PM1_3;
      endcase
   end

   assign cnt_inc      = cnt + 8'd1;
   assign stay_systole = ({1'b0, cnt_inc} < SYS_TICKS);
   assign fsm_state    = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         beat        <= 1'b0;
         led         <= 1'b0;
         rate_active <= 2'd0;
         beat_count  <= 8'd0;
      end else begin
         beat <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state       <= SYSTOLE;
                  cnt         <= 8'd0;
                  rate_active <= heartbeat;
                  beat        <= 1'b1;
                  led         <= 1'b1;
                  beat_count  <= beat_count + 8'd1;
               end
            end
            default: begin
               if (tick) begin
                  if (cnt == period_m1) begin
                     // Beat boundary: start the next beat or park in IDLE.
                     if (enable) begin
                        state       <= SYSTOLE;
                        cnt         <= 8'd0;
                        rate_active <= heartbeat;
                        beat        <= 1'b1;
                        led         <= 1'b1;
                        beat_count  <= beat_count + 8'd1;
                     end else begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        led   <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt_inc;
                     if (stay_systole) begin
                        state <= SYSTOLE;
                        led   <= 1'b1;
                     end else begin
                        state <= DIASTOLE;
                        led   <= 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// Directed bench for heartbeat_sequencer: beat spacing, systole length, rate sampling,
// enable drop, async reset mid-beat and beat_count wrap.
module tb_heartbeat_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       tick = 1'b0;
   logic [1:0] heartbeat = 2'd0;
   logic       beat;
   logic       led;
   logic [1:0] rate_active;
   logic [7:0] beat_count;
   logic [1:0] fsm_state;

   int n_checks = 0;
   int n_fail   = 0;
   int tick_div = 4;
   int ph       = 0;

   heartbeat_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .tick        (tick),
      .heartbeat   (heartbeat),
      .beat        (beat),
      .led         (led),
      .rate_active (rate_active),
      .beat_count  (beat_count),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   // Tick strobe: one cycle in every tick_div, changed away from the active edge.
   always @(negedge clk) begin
      if (ph >= tick_div - 1) begin
         tick = 1'b1;
         ph   = 0;
      end else begin
         tick = 1'b0;
         ph   = ph + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Starting on a beat edge, run until the next beat (or max clocks).
   task automatic measure(input int max, input int hb_at, input logic [1:0] hb_val,
                          input int en_at, output int clks, output int ticks,
                          output int leds, output int idle_at, output bit got);
      clks = 0; ticks = 0; leds = 1; idle_at = -1; got = 1'b0;
      while (!got && clks < max) begin
         if (clks == hb_at) heartbeat = hb_val;
         if (clks == en_at) enable = 1'b0;
         @(posedge clk); #1;
         clks++;
         if (tick) ticks++;
         if (beat) got = 1'b1;
         else if (led) leds++;
         if (idle_at < 0 && fsm_state == 2'd0) idle_at = clks;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int  clks, ticks, leds, idle_at, bad;
      bit  got;

      // Reset state
      #22;
      check("rst_beat", beat, 0);
      check("rst_led", led, 0);
      check("rst_rate", rate_active, 0);
      check("rst_count", beat_count, 0);
      check("rst_state", fsm_state, 0);
      #8 rst_n = 1'b1;

      // Idle with ticks running and enable low: nothing moves
      repeat (20) @(posedge clk);
      #1;
      check("idle_count", beat_count, 0);
      check("idle_led", led, 0);
      check("idle_state", fsm_state, 0);

      // Enable -> beat on the very next edge
      enable = 1'b1;
      @(posedge clk); #1;
      check("b1_beat", beat, 1);
      check("b1_rate", rate_active, 0);
      check("b1_count", beat_count, 1);
      check("b1_led", led, 1);
      check("b1_state", fsm_state, 1);

      measure(400, -1, 2'd0, -1, clks, ticks, leds, idle_at, got);
      check("b1_got", got, 1);
      check("b1_ticks", ticks, 48);
      check("b2_count", beat_count, 2);

      // Tick-aligned beat: full timing in clocks
      measure(400, -1, 2'd0, -1, clks, ticks, leds, idle_at, got);
      check("b2_got", got, 1);
      check("b2_clks", clks, 192);
      check("b2_led_clks", leds, 16);

      // Heartbeat 0->3 at tick 10: this beat still 48 ticks, next one 12
      measure(400, 40, 2'd3, -1, clks, ticks, leds, idle_at, got);
      check("b3_ticks", ticks, 48);
      check("b4_rate", rate_active, 3);
      measure(400, -1, 2'd0, -1, clks, ticks, leds, idle_at, got);
      check("b4_clks", clks, 48);
      check("b4_ticks", ticks, 12);
      check("b5_rate", rate_active, 3);

      // Move to class 2 mid-beat; takes effect at the following beat
      measure(400, 0, 2'd2, -1, clks, ticks, leds, idle_at, got);
      check("b5_ticks", ticks, 12);
      check("b6_rate", rate_active, 2);
      check("b6_count", beat_count, 6);

      // Enable dropped at tick 5 of a class-2 beat: finishes at tick 20, then IDLE
      measure(100, -1, 2'd0, 20, clks, ticks, leds, idle_at, got);
      check("drop_no_beat", got, 0);
      check("drop_idle_at", idle_at, 80);
      check("drop_led", led, 0);
      check("drop_state", fsm_state, 0);
      check("drop_count", beat_count, 6);

      enable = 1'b1;
      @(posedge clk); #1;
      check("reen_beat", beat, 1);
      check("reen_count", beat_count, 7);
      check("reen_rate", rate_active, 2);
      check("reen_led", led, 1);

      // Async reset pulsed between edges during systole
      #2 rst_n = 1'b0;
      #1;
      check("arst_led", led, 0);
      check("arst_count", beat_count, 0);
      check("arst_rate", rate_active, 0);
      check("arst_state", fsm_state, 0);
      heartbeat = 2'd3;
      tick_div  = 1;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_beat", beat, 1);
      check("post_rst_count", beat_count, 1);
      check("post_rst_rate", rate_active, 3);

      // tick every cycle at class 3: beat every 12 clk, led 4 clk
      measure(100, -1, 2'd0, -1, clks, ticks, leds, idle_at, got);
      check("fast_clks", clks, 12);
      check("fast_led_clks", leds, 4);
      check("fast_count", beat_count, 2);

      bad = 0;
      for (int i = 0; i < 254; i++) begin
         measure(100, -1, 2'd0, -1, clks, ticks, leds, idle_at, got);
         if (!got || clks != 12 || leds != 4) bad++;
      end
      check("fast_bad_beats", bad, 0);
      check("wrap_count", beat_count, 0);
      measure(100, -1, 2'd0, -1, clks, ticks, leds, idle_at, got);
      check("wrap_next", beat_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
